// File: rtl/uart_rx_pkt_ctrl.sv
// +--------------------------------------------------------------------------+
// | uart_rx_pkt_ctrl: frames UART bytes into cmd/len/payload/XOR packets,     |
// | buffers payload in a show-ahead FIFO. Option: UART_RX_PKT_TIMEOUT_EN.     |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
`default_nettype none

module uart_rx_pkt_ctrl #(
  parameter int MAX_LEN     = 16,
  parameter int FIFO_DEPTH  = 8,
  parameter int TIMEOUT_CYC = 20000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rx_data,
  input  logic       rx_done,
  output logic [7:0] pl_data,
  output logic       pl_valid,
  input  logic       pl_ready,
  output logic [7:0] pkt_cmd,
  output logic [7:0] pkt_len,
  output logic       pkt_done,
  output logic       pkt_ok,
  output logic       pkt_ovf,
  output logic       err_len,
  output logic       err_timeout,
  output logic       busy
);

  localparam int          c_aw      = $clog2(FIFO_DEPTH);
  localparam logic [7:0]  c_max_len = 8'(MAX_LEN);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_LEN     = 2'd1,
    S_PAYLOAD = 2'd2,
    S_CHK     = 2'd3
  } state_t;

  state_t          r_state;
  logic [7:0]      r_chk;
  logic [7:0]      r_rem;
  logic            r_ovf;

  logic [7:0]      r_mem [FIFO_DEPTH];
  logic [c_aw:0]   r_wr_ptr;
  logic [c_aw:0]   r_rd_ptr;
  logic            w_full;
  logic            w_pop;
  logic            w_push;
  logic [c_aw:0]   w_wr_nxt;
  logic [c_aw:0]   w_rd_nxt;
  logic            w_tmo_hit;

  assign w_full   = (r_wr_ptr[c_aw] != r_rd_ptr[c_aw]) &&
                    (r_wr_ptr[c_aw-1:0] == r_rd_ptr[c_aw-1:0]);
  assign w_pop    = pl_valid && pl_ready;
  // A pop frees the slot in the same cycle, so a full FIFO still takes the byte.
  assign w_push   = rx_done && (r_state == S_PAYLOAD) && (!w_full || w_pop);
  assign w_wr_nxt = r_wr_ptr + (c_aw+1)'(w_push);
  assign w_rd_nxt = r_rd_ptr + (c_aw+1)'(w_pop);

`ifdef UART_RX_PKT_TIMEOUT_EN
  localparam int             c_tw  = $clog2(TIMEOUT_CYC + 1);
  localparam logic [c_tw-1:0] c_tmo = c_tw'(TIMEOUT_CYC);
  logic [c_tw-1:0] r_tmo_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tmo_cnt <= '0;
    end else if (rx_done || r_state == S_IDLE) begin
      r_tmo_cnt <= '0;
    end else if (r_tmo_cnt != c_tmo) begin
      r_tmo_cnt <= r_tmo_cnt + 1'b1;
    end
  end

  assign w_tmo_hit = (r_state != S_IDLE) && (r_tmo_cnt == c_tmo) && !rx_done;
`else
  assign w_tmo_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_chk       <= '0;
      r_rem       <= '0;
      r_ovf       <= 1'b0;
      pkt_cmd     <= '0;
      pkt_len     <= '0;
      pkt_done    <= 1'b0;
      pkt_ok      <= 1'b0;
      pkt_ovf     <= 1'b0;
      err_len     <= 1'b0;
      err_timeout <= 1'b0;
      busy        <= 1'b0;
    end else begin
      pkt_done    <= 1'b0;
      err_len     <= 1'b0;
      err_timeout <= w_tmo_hit;
      if (rx_done) begin
        case (r_state)
          S_IDLE: begin
            pkt_cmd <= rx_data;
            r_chk   <= rx_data;
            r_ovf   <= 1'b0;
            r_state <= S_LEN;
            busy    <= 1'b1;
          end
          S_LEN: begin
            pkt_len <= rx_data;
            r_chk   <= r_chk ^ rx_data;
            if (rx_data > c_max_len) begin
              err_len <= 1'b1;
              r_state <= S_IDLE;
              busy    <= 1'b0;
            end else if (rx_data == 8'd0) begin
              r_state <= S_CHK;
            end else begin
              r_rem   <= rx_data;
              r_state <= S_PAYLOAD;
            end
          end
          S_PAYLOAD: begin
            r_chk <= r_chk ^ rx_data;
            if (!w_push) r_ovf <= 1'b1;
            r_rem <= r_rem - 8'd1;
            if (r_rem == 8'd1) r_state <= S_CHK;
          end
          default: begin
            pkt_done <= 1'b1;
            pkt_ok   <= (rx_data == r_chk) && !r_ovf;
            pkt_ovf  <= r_ovf;
            r_state  <= S_IDLE;
            busy     <= 1'b0;
          end
        endcase
      end else if (w_tmo_hit) begin
        r_state <= S_IDLE;
        busy    <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[c_aw-1:0]] <= rx_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      pl_valid <= 1'b0;
      pl_data  <= '0;
    end else begin
      r_wr_ptr <= w_wr_nxt;
      r_rd_ptr <= w_rd_nxt;
      pl_valid <= (w_wr_nxt != w_rd_nxt);
      // Bypass when the incoming byte becomes the new head.
      if (w_push || w_pop) begin
        if (w_push && (r_wr_ptr[c_aw-1:0] == w_rd_nxt[c_aw-1:0]))
          pl_data <= rx_data;
        else
          pl_data <= r_mem[w_rd_nxt[c_aw-1:0]];
      end
    end
  end

endmodule

`default_nettype wire
